// File: rtl/g_wb_arbiter_pkg.sv
// Shared widths, FIFO depth and source indices for the writeback arbiter.
// Holds no logic. Latency and backpressure are defined by the modules that use it.
package g_wb_arbiter_pkg;
    localparam int W_RD     = 4;
    localparam int W_OPR    = 32;
    localparam int REG_S    = 1 << W_RD;
    localparam int WB_DEPTH = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;
endpackage

// File: rtl/g_wb_fifo.sv
// DEPTH-entry {rd, result} queue. The head is visible as soon as it is written.
// A push while full or a pop while empty is dropped; full and empty come straight from the registered count.
module g_wb_fifo #(
    parameter int W_RD  = g_wb_arbiter_pkg::W_RD,
    parameter int W_OPR = g_wb_arbiter_pkg::W_OPR,
    parameter int DEPTH = g_wb_arbiter_pkg::WB_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W_RD-1:0]  rd_i,
    input  logic [W_OPR-1:0] result_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [W_RD-1:0]  head_rd_o,
    output logic [W_OPR-1:0] head_result_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W_RD-1:0]  rd_mem_q     [DEPTH];
    logic [W_OPR-1:0] result_mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign push_ok       = push_i & ~full_o;
    assign pop_ok        = pop_i & ~empty_o;
    assign head_rd_o     = rd_mem_q[head_q];
    assign head_result_o = result_mem_q[head_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + PW'(1);
        if (pop_ok)  head_d = head_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]     <= '0;
                result_mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_ok) begin
                rd_mem_q[tail_q]     <= rd_i;
                result_mem_q[tail_q] <= result_i;
            end
        end
    end
endmodule

// File: rtl/g_wb_arbiter.sv
// Round-robin arbiter that lets ALU and MEM results share one registered writeback port.
// Latency is 2 edges from accept to wb_o. Each ready is high while its own FIFO is below DEPTH entries.
module g_wb_arbiter #(
    parameter int W_RD  = g_wb_arbiter_pkg::W_RD,
    parameter int W_OPR = g_wb_arbiter_pkg::W_OPR,
    parameter int DEPTH = g_wb_arbiter_pkg::WB_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [W_RD-1:0]  alu_rd_i,
    input  logic [W_OPR-1:0] alu_result_i,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic [W_RD-1:0]  mem_rd_i,
    input  logic [W_OPR-1:0] mem_result_i,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic [W_OPR-1:0] result_o,
    output logic             pending_o
);
    import g_wb_arbiter_pkg::src_e;
    import g_wb_arbiter_pkg::SRC_ALU;
    import g_wb_arbiter_pkg::SRC_MEM;

    logic             alu_full, alu_empty, mem_full, mem_empty;
    logic [W_RD-1:0]  alu_head_rd, mem_head_rd;
    logic [W_OPR-1:0] alu_head_result, mem_head_result;
    logic             gnt_alu, gnt_mem;
    src_e             rr_q, rr_d;
    logic             wb_q, wb_d;
    logic [W_RD-1:0]  wb_r_q, wb_r_d;
    logic [W_OPR-1:0] result_q, result_d;

    assign alu_ready_o = ~alu_full;
    assign mem_ready_o = ~mem_full;

    g_wb_fifo #(.W_RD(W_RD), .W_OPR(W_OPR), .DEPTH(DEPTH)) u_alu_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (alu_valid_i & alu_ready_o),
        .rd_i          (alu_rd_i),
        .result_i      (alu_result_i),
        .pop_i         (gnt_alu),
        .full_o        (alu_full),
        .empty_o       (alu_empty),
        .head_rd_o     (alu_head_rd),
        .head_result_o (alu_head_result)
    );

    g_wb_fifo #(.W_RD(W_RD), .W_OPR(W_OPR), .DEPTH(DEPTH)) u_mem_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (mem_valid_i & mem_ready_o),
        .rd_i          (mem_rd_i),
        .result_i      (mem_result_i),
        .pop_i         (gnt_mem),
        .full_o        (mem_full),
        .empty_o       (mem_empty),
        .head_rd_o     (mem_head_rd),
        .head_result_o (mem_head_result)
    );

    // The pointer only moves when both heads compete, so a lone source never loses its turn.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        rr_d    = rr_q;
        if (!alu_empty && !mem_empty) begin
            if (rr_q == SRC_ALU) begin
                gnt_alu = 1'b1;
                rr_d    = SRC_MEM;
            end else begin
                gnt_mem = 1'b1;
                rr_d    = SRC_ALU;
            end
        end else if (!alu_empty) begin
            gnt_alu = 1'b1;
        end else if (!mem_empty) begin
            gnt_mem = 1'b1;
        end
    end

    always_comb begin
        wb_d     = gnt_alu | gnt_mem;
        wb_r_d   = gnt_mem ? mem_head_rd     : alu_head_rd;
        result_d = gnt_mem ? mem_head_result : alu_head_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q     <= SRC_ALU;
            wb_q     <= 1'b0;
            wb_r_q   <= '0;
            result_q <= '0;
        end else begin
            rr_q <= rr_d;
            wb_q <= wb_d;
            if (wb_d) begin
                wb_r_q   <= wb_r_d;
                result_q <= result_d;
            end
        end
    end

    assign wb_o      = wb_q;
    assign wb_r_o    = wb_r_q;
    assign result_o  = result_q;
    assign pending_o = ~alu_empty | ~mem_empty | wb_q;
endmodule

// File: tb/tb_g_wb_arbiter.sv
// Scoreboard bench for g_wb_arbiter: stimulus queues the expected writebacks and a negedge monitor retires them.
module tb_g_wb_arbiter;
    logic        clk;
    logic        reset;
    logic        alu_valid_i, mem_valid_i;
    logic        alu_ready_o, mem_ready_o;
    logic [3:0]  alu_rd_i, mem_rd_i;
    logic [31:0] alu_result_i, mem_result_i;
    logic        wb_o, pending_o;
    logic [3:0]  wb_r_o;
    logic [31:0] result_o;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    g_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_i     (alu_rd_i),
        .alu_result_i (alu_result_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_rd_i     (mem_rd_i),
        .mem_result_i (mem_result_i),
        .wb_o         (wb_o),
        .wb_r_o       (wb_r_o),
        .result_o     (result_o),
        .pending_o    (pending_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every writeback strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && wb_o) begin
            if (sb.size() == 0) begin
                check("wb_spurious", {31'b0, wb_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rd", {28'b0, wb_r_o}, {28'b0, mon_e.rd});
                check("wb_result", result_o, mon_e.res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((sb.size() != 0 || pending_o) && cyc < 30) begin
            tick();
            cyc++;
        end
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        check({name, "_idle"}, {31'b0, pending_o}, 32'd0);
    endtask

    initial begin
        int  ia, im;
        bit  acc_a, acc_m, saw_a, saw_m;

        reset = 1'b1;
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        alu_rd_i = '0; mem_rd_i = '0; alu_result_i = '0; mem_result_i = '0;

        // Reset state and idle
        #2;
        check("rst_wb", {31'b0, wb_o}, 32'd0);
        do_reset();
        check("idle_wb", {31'b0, wb_o}, 32'd0);
        check("idle_wb_r", {28'b0, wb_r_o}, 32'd0);
        check("idle_result", result_o, 32'd0);
        check("idle_pending", {31'b0, pending_o}, 32'd0);
        check("idle_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
        check("idle_mem_rdy", {31'b0, mem_ready_o}, 32'd1);

        // Single ALU push: visible after the second edge, for exactly one cycle
        alu_valid_i = 1'b1; alu_rd_i = 4'd3; alu_result_i = 32'hAA;
        sb.push_back({4'd3, 32'h0000_00AA});
        tick();
        alu_valid_i = 1'b0;
        check("single_wb_early", {31'b0, wb_o}, 32'd0);
        check("single_pending", {31'b0, pending_o}, 32'd1);
        tick();
        check("single_wb", {31'b0, wb_o}, 32'd1);
        check("single_rd", {28'b0, wb_r_o}, 32'd3);
        check("single_res", result_o, 32'hAA);
        tick();
        check("single_wb_off", {31'b0, wb_o}, 32'd0);
        check("single_hold_rd", {28'b0, wb_r_o}, 32'd3);
        check("single_hold_res", result_o, 32'hAA);
        drain("single");

        // Continuous contention: strict ALU/MEM alternation, starting with ALU
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            sb.push_back({4'(k), 32'h100 + 32'(k)});
            sb.push_back({4'(k + 8), 32'h200 + 32'(k + 8)});
        end
        ia = 0; im = 0; saw_a = 0; saw_m = 0;
        for (int cyc = 0; cyc < 20 && (ia < 4 || im < 4); cyc++) begin
            alu_valid_i = (ia < 4);
            alu_rd_i = 4'(ia + 1); alu_result_i = 32'h100 + 32'(ia + 1);
            mem_valid_i = (im < 4);
            mem_rd_i = 4'(im + 9); mem_result_i = 32'h200 + 32'(im + 9);
            acc_a = alu_valid_i && alu_ready_o;
            acc_m = mem_valid_i && mem_ready_o;
            if (alu_valid_i && !alu_ready_o) saw_a = 1;
            if (mem_valid_i && !mem_ready_o) saw_m = 1;
            tick();
            if (acc_a) ia++;
            if (acc_m) im++;
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("both_alu_accepted", ia, 32'd4);
        check("both_mem_accepted", im, 32'd4);
        check("both_alu_rdy_dropped", {31'b0, saw_a}, 32'd1);
        check("both_mem_rdy_dropped", {31'b0, saw_m}, 32'd1);
        drain("both");

        // MEM full while ALU idle: third MEM entry waits for a pop
        do_reset();
        sb.push_back({4'd5, 32'h500});
        sb.push_back({4'd2, 32'h302});
        sb.push_back({4'd3, 32'h303});
        sb.push_back({4'd4, 32'h304});
        alu_valid_i = 1'b1; alu_rd_i = 4'd5; alu_result_i = 32'h500;
        mem_valid_i = 1'b1; mem_rd_i = 4'd2; mem_result_i = 32'h302;
        tick();
        alu_valid_i = 1'b0;
        mem_rd_i = 4'd3; mem_result_i = 32'h303;
        tick();
        mem_rd_i = 4'd4; mem_result_i = 32'h304;
        check("memfull_rdy_low", {31'b0, mem_ready_o}, 32'd0);
        tick();
        check("memfull_rdy_back", {31'b0, mem_ready_o}, 32'd1);
        tick();
        mem_valid_i = 1'b0;
        drain("memfull");

        // Async reset mid-cycle with three entries queued
        do_reset();
        sb.push_back({4'd1, 32'h601});
        alu_valid_i = 1'b1; alu_rd_i = 4'd1; alu_result_i = 32'h601;
        mem_valid_i = 1'b1; mem_rd_i = 4'd9; mem_result_i = 32'h609;
        tick();
        alu_rd_i = 4'd2; alu_result_i = 32'h602;
        mem_rd_i = 4'd10; mem_result_i = 32'h60A;
        tick();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("arst_pre_pending", {31'b0, pending_o}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_wb", {31'b0, wb_o}, 32'd0);
        check("arst_wb_r", {28'b0, wb_r_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        check("arst_pending", {31'b0, pending_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        check("arst_no_stale", {31'b0, pending_o}, 32'd0);
        check("arst_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
        check("arst_mem_rdy", {31'b0, mem_ready_o}, 32'd1);
        sb.push_back({4'd7, 32'h777});
        alu_valid_i = 1'b1; alu_rd_i = 4'd7; alu_result_i = 32'h777;
        tick();
        alu_valid_i = 1'b0;
        drain("arst");

        // Full ALU FIFO: refuses the push even on the cycle it pops
        do_reset();
        sb.push_back({4'd1, 32'h701});
        sb.push_back({4'd8, 32'h708});
        sb.push_back({4'd2, 32'h702});
        sb.push_back({4'd3, 32'h703});
        sb.push_back({4'd4, 32'h704});
        alu_valid_i = 1'b1; alu_rd_i = 4'd1; alu_result_i = 32'h701;
        mem_valid_i = 1'b1; mem_rd_i = 4'd8; mem_result_i = 32'h708;
        tick();
        mem_valid_i = 1'b0;
        alu_rd_i = 4'd2; alu_result_i = 32'h702;
        tick();
        alu_rd_i = 4'd3; alu_result_i = 32'h703;
        tick();
        alu_rd_i = 4'd4; alu_result_i = 32'h704;
        check("alufull_rdy_low", {31'b0, alu_ready_o}, 32'd0);
        tick();
        check("alufull_rdy_after_pop", {31'b0, alu_ready_o}, 32'd1);
        tick();
        check("alufull_pushpop_rdy", {31'b0, alu_ready_o}, 32'd1);
        alu_valid_i = 1'b0;
        drain("alufull");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
